// File: rtl/z80_im2_int_ctrl.sv
// rtl/z80_im2_int_ctrl.sv - Z80 mode-2 interrupt controller: timer plus three edge sources, vectored INTA, RETI snoop
module z80_im2_int_ctrl #(
    parameter logic [7:0]  BASE_PORT = 8'h80,
    parameter int unsigned TIMER_DIV = 5000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       nM1,
    input  logic       nIORQ,
    input  logic       nMREQ,
    input  logic       nRD,
    input  logic       nWR,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [2:0] irq_req,
    output logic       nINT
);

    localparam logic [7:0]  PORT_VBASE = BASE_PORT;
    localparam logic [7:0]  PORT_MASK  = BASE_PORT + 8'd1;
    localparam logic [7:0]  PORT_STAT  = BASE_PORT + 8'd2;
    localparam logic [15:0] TIMER_LAST = 16'(TIMER_DIV - 1);

    typedef enum logic {IDLE, GOT_ED} reti_state_t;

    reti_state_t state_q, state_d;
    logic [7:3]  vbase_q, vbase_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  in_service_q, in_service_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  irq_q, irq_d;
    logic        nint_q, nint_d;
    logic        inta_q, inta_d;
    logic        wr_q, wr_d;
    logic        fetch_q, fetch_d;
    logic        ack_valid_q, ack_valid_d;
    logic [1:0]  ack_k_q, ack_k_d;

    logic       inta, io_wr, io_rd, fetch, wr_first, inta_first, ack;
    logic       byte_valid, reti, timer_wrap, req_any;
    logic [3:0] req, set_bits;
    logic [1:0] req_k, vec_k;

    assign inta       = ~nM1 & ~nIORQ;
    assign io_wr      = nM1 & ~nIORQ & ~nWR;
    assign io_rd      = nM1 & ~nIORQ & ~nRD & (A == PORT_STAT);
    assign fetch      = ~nM1 & ~nMREQ & ~nRD;
    assign wr_first   = io_wr & ~wr_q;
    assign inta_first = inta & ~inta_q;
    // The opcode byte is taken on the cycle nRD has just risen after an M1 fetch.
    assign byte_valid = fetch_q & nRD;

    always_comb begin
        req     = pending_q & ~mask_q;
        req_any = |req;
        if (req[0])      req_k = 2'd0;
        else if (req[1]) req_k = 2'd1;
        else if (req[2]) req_k = 2'd2;
        else             req_k = 2'd3;
        ack = inta_first & req_any;
    end

    always_comb begin
        state_d = state_q;
        reti    = 1'b0;
        if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (D_in == 8'hED) state_d = GOT_ED;
                end
                GOT_ED: begin
                    if (D_in == 8'h4D) begin
                        reti    = 1'b1;
                        state_d = IDLE;
                    end else if (D_in != 8'hED) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        timer_wrap = (timer_q == TIMER_LAST);
        timer_d    = timer_wrap ? 16'd0 : timer_q + 16'd1;
        irq_d      = irq_req;
        set_bits   = {irq_req & ~irq_q, timer_wrap};

        pending_d    = pending_q;
        in_service_d = in_service_q;
        if (reti) in_service_d = 4'h0;
        if (ack) begin
            pending_d[req_k]    = 1'b0;
            in_service_d[req_k] = 1'b1;
        end
        // A fresh edge landing on the acknowledge cycle must not be lost.
        pending_d = pending_d | set_bits;

        vbase_d = vbase_q;
        mask_d  = mask_q;
        if (wr_first && A == PORT_VBASE) vbase_d = D_in[7:3];
        if (wr_first && A == PORT_MASK)  mask_d  = D_in[3:0];

        inta_d  = inta;
        wr_d    = io_wr;
        fetch_d = fetch;

        ack_valid_d = ack_valid_q;
        ack_k_d     = ack_k_q;
        if (inta_first) begin
            ack_valid_d = req_any;
            ack_k_d     = req_k;
        end

        nint_d = ack | ~(req_any & (in_service_q == 4'h0));
    end

    always_comb begin
        D_oe  = 1'b0;
        D_out = 8'h00;
        vec_k = req_k;
        if (!RESET) begin
            if (inta) begin
                D_oe  = inta_q ? ack_valid_q : req_any;
                vec_k = inta_q ? ack_k_q : req_k;
                if (D_oe) D_out = {vbase_q, vec_k, 1'b0};
            end else if (io_rd) begin
                D_oe  = 1'b1;
                D_out = {pending_q, in_service_q};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            vbase_q      <= 5'h00;
            mask_q       <= 4'hF;
            pending_q    <= 4'h0;
            in_service_q <= 4'h0;
            timer_q      <= 16'd0;
            irq_q        <= 3'b000;
            nint_q       <= 1'b1;
            inta_q       <= 1'b0;
            wr_q         <= 1'b0;
            fetch_q      <= 1'b0;
            ack_valid_q  <= 1'b0;
            ack_k_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            vbase_q      <= vbase_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            timer_q      <= timer_d;
            irq_q        <= irq_d;
            nint_q       <= nint_d;
            inta_q       <= inta_d;
            wr_q         <= wr_d;
            fetch_q      <= fetch_d;
            ack_valid_q  <= ack_valid_d;
            ack_k_q      <= ack_k_d;
        end
    end

    assign nINT = nint_q;

endmodule
